and_gate: RTL and testbench

- Bitwise AND unit for the CPU datapath's logic operations.
- Provides a zero-latency combinational result `out = d1 & d2`, usable as a plain gate.
- Also provides a one-cycle registered copy with valid tracking and status flags (zero, all-ones, ones count) for the ALU flag logic.
- With WIDTH=1 it is a drop-in 2-input AND gate.

---
 rtl/and_gate_pkg.sv | 23 ++
 rtl/and_popcount.sv | 42 ++++
 rtl/and_gate.sv | 81 ++++++++
 tb/tb_and_gate.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/and_gate_pkg.sv
// and_gate_pkg: shared constants, types and helpers for the bitwise AND unit.
//   AND_WIDTH_DEFAULT - default operand/result width (plain 2-input gate).
//   AND_CNT_W_MAX     - ones-count width needed at the widest legal WIDTH (64).
//   calc_cnt_w()      - width of a ones count able to hold the value WIDTH.
//   and_flags_t       - packed {zero, ones, cnt} bundle consumed by the ALU flag mux.
package and_gate_pkg;

  localparam int AND_WIDTH_DEFAULT = 1;
  localparam int AND_WIDTH_MAX     = 64;
  localparam int AND_CNT_W_MAX     = $clog2(AND_WIDTH_MAX + 1);

  // A count of WIDTH bits ranges 0..WIDTH inclusive, so WIDTH+1 distinct values.
  function automatic int calc_cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

  typedef struct packed {
    logic                     zero;
    logic                     ones;
    logic [AND_CNT_W_MAX-1:0] cnt;
  } and_flags_t;

endpackage

// File: rtl/and_popcount.sv
// and_popcount: combinational ones counter built as a recursive adder tree.
//   i_data [WIDTH-1:0] - vector to count.
//   o_cnt  [CNT_W-1:0] - number of 1 bits in i_data (0..WIDTH).
// Each node splits its input in two halves, counts each half in a child
// instance, and adds the two child counts; a single bit is its own count.
module and_popcount
  import and_gate_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int CNT_W = calc_cnt_w(WIDTH)
) (
  input  logic [WIDTH-1:0] i_data,
  output logic [CNT_W-1:0] o_cnt
);

  if (WIDTH == 1) begin : g_leaf
    assign o_cnt = CNT_W'(i_data);
  end else begin : g_node
    localparam int LO_W  = WIDTH / 2;
    localparam int HI_W  = WIDTH - LO_W;
    localparam int LO_CW = calc_cnt_w(LO_W);
    localparam int HI_CW = calc_cnt_w(HI_W);

    logic [LO_CW-1:0] w_lo_cnt;
    logic [HI_CW-1:0] w_hi_cnt;

    and_popcount #(.WIDTH(LO_W), .CNT_W(LO_CW)) u_lo (
      .i_data (i_data[LO_W-1:0]),
      .o_cnt  (w_lo_cnt)
    );

    and_popcount #(.WIDTH(HI_W), .CNT_W(HI_CW)) u_hi (
      .i_data (i_data[WIDTH-1:LO_W]),
      .o_cnt  (w_hi_cnt)
    );

    // Both child counts are strictly narrower-or-equal to CNT_W, so the
    // zero-extended sum cannot overflow.
    assign o_cnt = CNT_W'(w_lo_cnt) + CNT_W'(w_hi_cnt);
  end

endmodule

// File: rtl/and_gate.sv
// and_gate: bitwise AND unit for the datapath logic operations.
//   clk       - rising-edge clock.
//   rst_n     - asynchronous active-low reset.
//   d1, d2    - operands [WIDTH-1:0].
//   out       - combinational d1 & d2 (no clock/reset dependence).
//   in_valid  - qualifies d1/d2 for capture into the registered stage.
//   out_q     - registered result, one cycle after capture.
//   out_valid - out_q was captured on the most recent edge.
//   zero_q    - registered flag: result == 0.
//   ones_q    - registered flag: result is all ones.
//   cnt_q     - registered ones count of the result [CNT_W-1:0].
// Handshake: valid-only. A beat is accepted on every rising edge where
// in_valid is high; there is no ready, so the unit can never stall. When
// in_valid is low, out_valid drops and the result/flags hold their values.
module and_gate
  import and_gate_pkg::*;
#(
  parameter  int WIDTH = AND_WIDTH_DEFAULT,
  localparam int CNT_W = calc_cnt_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  output logic [WIDTH-1:0] out,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out_q,
  output logic             out_valid,
  output logic             zero_q,
  output logic             ones_q,
  output logic [CNT_W-1:0] cnt_q
);

  logic [WIDTH-1:0] w_and;
  logic [CNT_W-1:0] w_cnt;
  logic             w_zero;
  logic             w_ones;

  logic [WIDTH-1:0] r_out_q;
  logic             r_out_valid;
  logic             r_zero_q;
  logic             r_ones_q;
  logic [CNT_W-1:0] r_cnt_q;

  assign w_and  = d1 & d2;
  assign w_zero = (w_and == '0);
  assign w_ones = (w_and == '1);

  and_popcount #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_popcount (
    .i_data (w_and),
    .o_cnt  (w_cnt)
  );

  // Result and all flags load together from the same w_and, so they always
  // describe one and the same captured result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_q     <= '0;
      r_out_valid <= 1'b0;
      r_zero_q    <= 1'b1;
      r_ones_q    <= 1'b0;
      r_cnt_q     <= '0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_out_q  <= w_and;
        r_zero_q <= w_zero;
        r_ones_q <= w_ones;
        r_cnt_q  <= w_cnt;
      end
    end
  end

  assign out       = w_and;
  assign out_q     = r_out_q;
  assign out_valid = r_out_valid;
  assign zero_q    = r_zero_q;
  assign ones_q    = r_ones_q;
  assign cnt_q     = r_cnt_q;

endmodule

// File: tb/tb_and_gate.sv
module tb_and_gate;

  logic clk;
  logic rst_n;

  int n_checks;
  int n_fail;

  // WIDTH=1 instance
  logic       a1_d1, a1_d2, a1_out, a1_iv, a1_q, a1_v, a1_z, a1_o;
  logic [0:0] a1_cnt;

  // WIDTH=8 instance
  logic [7:0] a8_d1, a8_d2, a8_out, a8_q;
  logic       a8_iv, a8_v, a8_z, a8_o;
  logic [3:0] a8_cnt;

  // WIDTH=13 instance
  logic [12:0] a13_d1, a13_d2, a13_out, a13_q;
  logic        a13_iv, a13_v, a13_z, a13_o;
  logic [3:0]  a13_cnt;

  and_gate u_w1 (
    .clk(clk), .rst_n(rst_n), .d1(a1_d1), .d2(a1_d2), .out(a1_out),
    .in_valid(a1_iv), .out_q(a1_q), .out_valid(a1_v), .zero_q(a1_z),
    .ones_q(a1_o), .cnt_q(a1_cnt)
  );

  and_gate #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .d1(a8_d1), .d2(a8_d2), .out(a8_out),
    .in_valid(a8_iv), .out_q(a8_q), .out_valid(a8_v), .zero_q(a8_z),
    .ones_q(a8_o), .cnt_q(a8_cnt)
  );

  and_gate #(.WIDTH(13)) u_w13 (
    .clk(clk), .rst_n(rst_n), .d1(a13_d1), .d2(a13_d2), .out(a13_out),
    .in_valid(a13_iv), .out_q(a13_q), .out_valid(a13_v), .zero_q(a13_z),
    .ones_q(a13_o), .cnt_q(a13_cnt)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (a8_q !== 8'h00) begin n_fail++; $display("FAIL reset_out_q8: got %h expected 00", a8_q); end
    n_checks++; if (a8_v !== 1'b0) begin n_fail++; $display("FAIL reset_valid8: got %b expected 0", a8_v); end
    n_checks++; if (a8_z !== 1'b1) begin n_fail++; $display("FAIL reset_zero8: got %b expected 1", a8_z); end
    n_checks++; if (a8_o !== 1'b0) begin n_fail++; $display("FAIL reset_ones8: got %b expected 0", a8_o); end
    n_checks++; if (a8_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_cnt8: got %0d expected 0", a8_cnt); end
    n_checks++; if (a13_q !== 13'h0 || a13_v !== 1'b0 || a13_z !== 1'b1 || a13_o !== 1'b0 || a13_cnt !== 4'd0) begin
      n_fail++; $display("FAIL reset_w13: got q=%h v=%b z=%b o=%b c=%0d expected q=0 v=0 z=1 o=0 c=0",
                         a13_q, a13_v, a13_z, a13_o, a13_cnt);
    end
    n_checks++; if (a1_q !== 1'b0 || a1_v !== 1'b0 || a1_z !== 1'b1 || a1_o !== 1'b0 || a1_cnt !== 1'b0) begin
      n_fail++; $display("FAIL reset_w1: got q=%b v=%b z=%b o=%b c=%b expected q=0 v=0 z=1 o=0 c=0",
                         a1_q, a1_v, a1_z, a1_o, a1_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_comb_w1();
    logic [1:0] vec_d1 [4];
    logic [1:0] vec_d2 [4];
    logic       vec_exp [4];
    vec_d1 = '{2'd0, 2'd1, 2'd1, 2'd0};
    vec_d2 = '{2'd0, 2'd0, 2'd1, 2'd1};
    vec_exp = '{1'b0, 1'b0, 1'b1, 1'b0};
    a1_iv = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a1_d1 = vec_d1[i][0];
      a1_d2 = vec_d2[i][0];
      #1;
      n_checks++; if (a1_out !== vec_exp[i]) begin
        n_fail++; $display("FAIL comb_w1[%0d]: got %b expected %b", i, a1_out, vec_exp[i]);
      end
      #49;
    end
  endtask

  task automatic test_corner_w1();
    @(negedge clk);
    a1_d1 = 1'b1; a1_d2 = 1'b1; a1_iv = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (a1_q !== 1'b1 || a1_o !== 1'b1 || a1_z !== 1'b0 || a1_cnt !== 1'b1 || a1_v !== 1'b1) begin
      n_fail++; $display("FAIL corner_w1_one: got q=%b o=%b z=%b c=%b v=%b expected q=1 o=1 z=0 c=1 v=1",
                         a1_q, a1_o, a1_z, a1_cnt, a1_v);
    end
    @(negedge clk);
    a1_d1 = 1'b1; a1_d2 = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (a1_q !== 1'b0 || a1_o !== 1'b0 || a1_z !== 1'b1 || a1_cnt !== 1'b0) begin
      n_fail++; $display("FAIL corner_w1_zero: got q=%b o=%b z=%b c=%b expected q=0 o=0 z=1 c=0",
                         a1_q, a1_o, a1_z, a1_cnt);
    end
    @(negedge clk);
    a1_iv = 1'b0;
  endtask

  task automatic test_capture_w8();
    @(negedge clk);
    a8_d1 = 8'hF0; a8_d2 = 8'h3C; a8_iv = 1'b1;
    #1;
    n_checks++; if (a8_out !== 8'h30) begin n_fail++; $display("FAIL comb_w8: got %h expected 30", a8_out); end
    @(posedge clk); #1;
    n_checks++; if (a8_q !== 8'h30) begin n_fail++; $display("FAIL cap_out_q: got %h expected 30", a8_q); end
    n_checks++; if (a8_z !== 1'b0 || a8_o !== 1'b0) begin n_fail++; $display("FAIL cap_flags: got z=%b o=%b expected z=0 o=0", a8_z, a8_o); end
    n_checks++; if (a8_cnt !== 4'd2) begin n_fail++; $display("FAIL cap_cnt: got %0d expected 2", a8_cnt); end
    n_checks++; if (a8_v !== 1'b1) begin n_fail++; $display("FAIL cap_valid: got %b expected 1", a8_v); end
    @(negedge clk);
    a8_iv = 1'b0; a8_d1 = 8'hFF; a8_d2 = 8'hFF;
    @(posedge clk); #1;
    n_checks++; if (a8_v !== 1'b0) begin n_fail++; $display("FAIL hold_valid: got %b expected 0", a8_v); end
    n_checks++; if (a8_q !== 8'h30 || a8_cnt !== 4'd2 || a8_o !== 1'b0) begin
      n_fail++; $display("FAIL hold_data: got q=%h c=%0d o=%b expected q=30 c=2 o=0", a8_q, a8_cnt, a8_o);
    end
  endtask

  task automatic test_flags_w8();
    @(negedge clk);
    a8_d1 = 8'hFF; a8_d2 = 8'hFF; a8_iv = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (a8_q !== 8'hFF || a8_o !== 1'b1 || a8_z !== 1'b0 || a8_cnt !== 4'd8) begin
      n_fail++; $display("FAIL flags_all_ones: got q=%h o=%b z=%b c=%0d expected q=ff o=1 z=0 c=8", a8_q, a8_o, a8_z, a8_cnt);
    end
    @(negedge clk);
    a8_d1 = 8'hAA; a8_d2 = 8'h55;
    @(posedge clk); #1;
    n_checks++; if (a8_q !== 8'h00 || a8_o !== 1'b0 || a8_z !== 1'b1 || a8_cnt !== 4'd0) begin
      n_fail++; $display("FAIL flags_zero: got q=%h o=%b z=%b c=%0d expected q=00 o=0 z=1 c=0", a8_q, a8_o, a8_z, a8_cnt);
    end
    @(negedge clk);
    a8_iv = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] vec_d1 [3];
    logic [7:0] vec_d2 [3];
    logic [7:0] exp_q [$];
    logic [3:0] exp_cnt [$];
    logic [7:0] e_q;
    logic [3:0] e_c;
    vec_d1 = '{8'hFF, 8'hFF, 8'h81};
    vec_d2 = '{8'h0F, 8'hF0, 8'hFF};
    exp_q = '{8'h0F, 8'hF0, 8'h81};
    exp_cnt = '{4'd4, 4'd4, 4'd2};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a8_d1 = vec_d1[i]; a8_d2 = vec_d2[i]; a8_iv = 1'b1;
      @(posedge clk); #1;
      e_q = exp_q.pop_front();
      e_c = exp_cnt.pop_front();
      n_checks++; if (a8_q !== e_q || a8_cnt !== e_c || a8_v !== 1'b1) begin
        n_fail++; $display("FAIL b2b[%0d]: got q=%h c=%0d v=%b expected q=%h c=%0d v=1", i, a8_q, a8_cnt, a8_v, e_q, e_c);
      end
    end
    @(negedge clk);
    a8_iv = 1'b0;
  endtask

  task automatic test_reset_mid_cycle();
    @(negedge clk);
    a8_d1 = 8'hFF; a8_d2 = 8'hFF; a8_iv = 1'b1;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++; if (a8_q !== 8'h00 || a8_v !== 1'b0 || a8_z !== 1'b1 || a8_o !== 1'b0 || a8_cnt !== 4'd0) begin
      n_fail++; $display("FAIL async_reset: got q=%h v=%b z=%b o=%b c=%0d expected q=00 v=0 z=1 o=0 c=0",
                         a8_q, a8_v, a8_z, a8_o, a8_cnt);
    end
    // in_valid still high across this edge, but reset discards the capture
    @(posedge clk); #1;
    n_checks++; if (a8_q !== 8'h00 || a8_v !== 1'b0) begin
      n_fail++; $display("FAIL reset_discard: got q=%h v=%b expected q=00 v=0", a8_q, a8_v);
    end
    @(negedge clk);
    a8_iv = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_random_w13();
    logic [12:0] m_q;
    logic        m_v, m_z, m_o;
    logic [3:0]  m_c;
    logic [12:0] n_q;
    logic [3:0]  n_c;
    int          cnt_acc;
    m_q = 13'h0; m_v = 1'b0; m_z = 1'b1; m_o = 1'b0; m_c = 4'd0;
    for (int it = 0; it < 1000; it++) begin
      @(negedge clk);
      a13_d1 = 13'($urandom_range(0, 8191));
      a13_d2 = 13'($urandom_range(0, 8191));
      a13_iv = 1'($urandom_range(0, 1));
      n_q = a13_d1 & a13_d2;
      cnt_acc = 0;
      for (int b = 0; b < 13; b++) if (n_q[b]) cnt_acc++;
      n_c = 4'(cnt_acc);
      #1;
      n_checks++; if (a13_out !== n_q) begin
        n_fail++; $display("FAIL rand_comb[%0d]: got %h expected %h", it, a13_out, n_q);
      end
      @(posedge clk); #1;
      m_v = a13_iv;
      if (a13_iv) begin
        m_q = n_q; m_c = n_c; m_z = (cnt_acc == 0); m_o = (cnt_acc == 13);
      end
      n_checks++; if (a13_q !== m_q || a13_v !== m_v || a13_z !== m_z || a13_o !== m_o || a13_cnt !== m_c) begin
        n_fail++; $display("FAIL rand_reg[%0d]: got q=%h v=%b z=%b o=%b c=%0d expected q=%h v=%b z=%b o=%b c=%0d",
                           it, a13_q, a13_v, a13_z, a13_o, a13_cnt, m_q, m_v, m_z, m_o, m_c);
      end
    end
    @(negedge clk);
    a13_iv = 1'b0;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n  = 1'b0;
    a1_d1  = 1'b0; a1_d2 = 1'b0; a1_iv = 1'b0;
    a8_d1  = 8'h00; a8_d2 = 8'h00; a8_iv = 1'b0;
    a13_d1 = 13'h0; a13_d2 = 13'h0; a13_iv = 1'b0;

    test_reset();
    test_comb_w1();
    test_corner_w1();
    test_capture_w8();
    test_flags_w8();
    test_back_to_back();
    test_reset_mid_cycle();
    test_random_w13();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
